// File: rtl/ro_freq_monitor.sv
// ro_freq_monitor: counts synchronised rising edges of a ring-oscillator tap
// over a programmed window of reference cycles (start/busy/done handshake).
// Optional feature macro: RO_FREQ_MONITOR_STUCK_EN adds the STUCK output,
// flagging a non-zero window in which no oscillator edge was seen.
module ro_freq_monitor #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic             RO_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
`ifdef RO_FREQ_MONITOR_STUCK_EN
  output logic             OVF,
  output logic             STUCK
`else
  output logic             OVF
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic             settle_q, settle_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             edge_det;
`ifdef RO_FREQ_MONITOR_STUCK_EN
  logic             stuck_q, stuck_d;
`endif

  // Synchroniser chain: s1/s2 resolve metastability, s3 is the previous s2.
  always_comb begin
    s1_d     = RO_IN;
    s2_d     = s1_q;
    s3_d     = s2_q;
    edge_det = s2_q & ~s3_q;
  end

  // Next-state, window/count datapath and registered status outputs.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    win_d    = win_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
`ifdef RO_FREQ_MONITOR_STUCK_EN
    stuck_d  = stuck_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          win_d    = WINDOW;
          count_d  = '0;
          ovf_d    = 1'b0;
          settle_d = 1'b0;
`ifdef RO_FREQ_MONITOR_STUCK_EN
          stuck_d  = 1'b0;
`endif
          state_d  = (WINDOW == '0) ? ST_DONE : ST_SETTLE;
        end
      end
      // Two cycles to flush stale synchroniser contents; edges ignored.
      ST_SETTLE: begin
        settle_d = 1'b1;
        if (settle_q) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        win_d = win_q - WIN_W'(1);
        if (edge_det) begin
          // An edge arriving at full scale is lost: hold and flag overflow.
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + CNT_W'(1);
        end
        if (win_q == WIN_W'(1)) begin
          state_d = ST_DONE;
`ifdef RO_FREQ_MONITOR_STUCK_EN
          // Count never wraps, so a zero final count means no edge at all.
          stuck_d = (count_d == '0);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered copies of the state, one cycle behind.
    busy_d = (state_q == ST_SETTLE) || (state_q == ST_COUNT);
    done_d = (state_q == ST_DONE);
  end

  // State and datapath registers, all cleared by asynchronous reset.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      settle_q <= 1'b0;
      win_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      settle_q <= settle_d;
      win_q    <= win_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef RO_FREQ_MONITOR_STUCK_EN
  // Stuck flag register.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) stuck_q <= 1'b0;
    else     stuck_q <= stuck_d;
  end
  assign STUCK = stuck_q;
`endif

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign COUNT = count_q;
  assign OVF   = ovf_q;

endmodule
